regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries per requester write buffer (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock shared with regfile.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port a_valid  input  1  requester A write request.
REQ-005 SHALL have port a_ready  output  1  requester A buffer can accept.
REQ-006 SHALL have port a_dst  input  3  requester A destination register.
REQ-007 SHALL have port a_data  input  32  requester A write data.
REQ-008 SHALL have ports b_valid, b_ready, b_dst, b_data with the same directions, widths and meanings for requester B.
REQ-009 SHALL have port rf_w  output  3  regfile write address.
REQ-010 SHALL have port rf_we  output  1  regfile write enable.
REQ-011 SHALL have port rf_in  output  32  regfile write data.
REQ-012 SHALL have port pending  output  8  bit i set while any buffered write targets register i.

Function
REQ-013 SHALL accept a request on a rising clk edge where x_valid and x_ready are both 1, pushing {dst,data} into that requester's FIFO.
REQ-014 SHALL drive x_ready = (entry count < DEPTH), from registered state only, with no combinational path from x_valid or the other requester.
REQ-015 SHALL hold x_ready at 0 when full, even in a cycle where that FIFO pops.
REQ-016 SHALL drive rf_we, rf_w, rf_in combinationally from the granted FIFO head; rf_we = 1 iff at least one FIFO is non-empty.
REQ-017 SHALL pop the granted head on the same edge the regfile samples it, so an accept at edge N is written into the regfile at edge N+1 at the earliest.
REQ-018 SHALL grant the only non-empty FIFO when one is empty.
REQ-019 SHALL, when both are non-empty, grant the requester not granted last (round-robin); last_grant updates only on an actual pop.
REQ-020 SHALL preserve write order within each requester; cross-requester order to the same register follows grant order only.
REQ-021 SHALL allow push and pop of the same FIFO on one edge (count unchanged); push into an empty FIFO is not written the same cycle.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-023 SHALL compute pending[i] as OR over all valid entries of both FIFOs with dst == i, including the current head.
REQ-024 SHALL ignore x_dst/x_data when x_valid is 0.

Reset
REQ-025 SHALL, on reset assertion, asynchronously clear both FIFOs and set last_grant = B, giving A priority on the first tie.
REQ-026 SHALL output during reset: rf_we=0, rf_w=0, rf_in=0, pending=8'h00, a_ready=1, b_ready=1 (after the asynchronous clear).
REQ-027 SHALL discard buffered writes on reset mid-operation; no regfile write occurs on an edge where reset is high.

Structure
REQ-028 SHALL take REG_ADDR_W=3, DATA_W=32, NUM_REGS=8 and requester-id enum {REQ_A, REQ_B} from a shared regfile package.
REQ-029 SHALL implement each buffer as one sub-module, wr_fifo (parameter DEPTH, ports clk, reset, push, pop, din, dout, empty, full, entry-valid/dst vectors), instantiated twice.

Verification
REQ-030 Single writer: A pushes r0 = 32'hABCDABCD at edge 1, B idle -> rf_we=1, rf_w=0, rf_in=32'hABCDABCD in cycle 1-2; regfile r0 = 32'hABCDABCD after edge 2; pending[0] high for one cycle.
REQ-031 Tie: A (r0, 32'hABCDABCD) and B (r1, 32'hDEADBEEF) both accepted at edge 1 after reset -> A written at edge 2, B at edge 3; read ports r1=0, r2=1 show both values afterward.
REQ-032 Backpressure: A and B push every cycle with DEPTH=2 -> grants alternate A,B,A,B; each x_ready drops to 0 once count reaches 2; no request lost; write count equals accept count.
REQ-033 Same-register collision: A writes r3=32'h11111111, B writes r3=32'h22222222 same edge, last_grant=B -> final r3 = 32'h22222222; pending[3] clears only after both writes.
REQ-034 Reset mid-operation: both FIFOs full, reset pulsed between edges -> rf_we and pending drop immediately, both ready=1, no further regfile write until new requests.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared regfile widths and requester ids
package regfile_write_arbiter_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 8;
   localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_wr_fifo.sv
// rtl/regfile_write_arbiter_wr_fifo.sv - per-requester write buffer, {dst,data} entries
module wr_fifo
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [ENTRY_W-1:0]            din,
   output logic [ENTRY_W-1:0]            dout,
   output logic                          empty,
   output logic                          full,
   output logic [DEPTH-1:0]              ent_valid,
   output logic [DEPTH*REG_ADDR_W-1:0]   ent_dst
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]   r_vld;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W:0]     r_count;
   logic               w_push;
   logic               w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (PTR_W+1)'(DEPTH));
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rd_ptr];
   assign ent_valid = r_vld;

   // Pointers are PTR_W bits wide, so increment wraps modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_vld    <= '0;
      end else begin
         if (w_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_dst
      assign ent_dst[g*REG_ADDR_W +: REG_ADDR_W] = r_mem[g][ENTRY_W-1 -: REG_ADDR_W];
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two buffered requesters sharing one regfile write port, round-robin
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [REG_ADDR_W-1:0] a_dst,
   input  logic [DATA_W-1:0]     a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [REG_ADDR_W-1:0] b_dst,
   input  logic [DATA_W-1:0]     b_data,
   output logic [REG_ADDR_W-1:0] rf_w,
   output logic                  rf_we,
   output logic [DATA_W-1:0]     rf_in,
   output logic [NUM_REGS-1:0]   pending
);

   req_id_e                       r_last_grant;
   req_id_e                       w_grant;
   logic                          w_a_empty, w_a_full, w_b_empty, w_b_full;
   logic                          w_a_push, w_a_pop, w_b_push, w_b_pop;
   logic [ENTRY_W-1:0]            w_a_dout, w_b_dout, w_head;
   logic [DEPTH-1:0]              w_a_vld, w_b_vld;
   logic [DEPTH*REG_ADDR_W-1:0]   w_a_dst_vec, w_b_dst_vec;

   assign a_ready  = ~w_a_full;
   assign b_ready  = ~w_b_full;
   assign w_a_push = a_valid & a_ready;
   assign w_b_push = b_valid & b_ready;
   assign rf_we    = ~w_a_empty | ~w_b_empty;
   assign w_a_pop  = rf_we & (w_grant == REQ_A);
   assign w_b_pop  = rf_we & (w_grant == REQ_B);

   wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .reset     (reset),
      .push      (w_a_push),
      .pop       (w_a_pop),
      .din       ({a_dst, a_data}),
      .dout      (w_a_dout),
      .empty     (w_a_empty),
      .full      (w_a_full),
      .ent_valid (w_a_vld),
      .ent_dst   (w_a_dst_vec)
   );

   wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .reset     (reset),
      .push      (w_b_push),
      .pop       (w_b_pop),
      .din       ({b_dst, b_data}),
      .dout      (w_b_dout),
      .empty     (w_b_empty),
      .full      (w_b_full),
      .ent_valid (w_b_vld),
      .ent_dst   (w_b_dst_vec)
   );

   // On a tie, the requester that was not served last wins.
   always_comb begin
      w_grant = REQ_A;
      if (w_a_empty) begin
         w_grant = REQ_B;
      end else if (!w_b_empty && r_last_grant == REQ_A) begin
         w_grant = REQ_B;
      end
   end

   assign w_head = (w_grant == REQ_A) ? w_a_dout : w_b_dout;
   assign rf_w   = rf_we ? w_head[ENTRY_W-1 -: REG_ADDR_W] : '0;
   assign rf_in  = rf_we ? w_head[DATA_W-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= REQ_B;
      end else if (rf_we) begin
         r_last_grant <= w_grant;
      end
   end

   always_comb begin
      pending = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (w_a_vld[e] && w_a_dst_vec[e*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) begin
               pending[r] = 1'b1;
            end
            if (w_b_vld[e] && w_b_dst_vec[e*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r)) begin
               pending[r] = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench with queue-based arbiter model
module tb_regfile_write_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [2:0]  a_dst, b_dst;
   logic [31:0] a_data, b_data;
   logic [2:0]  rf_w;
   logic        rf_we;
   logic [31:0] rf_in;
   logic [7:0]  pending;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc = 0;
   int wr_cnt = 0;
   int saved_wr;

   logic [31:0] regs [8];
   logic [34:0] qa [$];
   logic [34:0] qb [$];
   logic        m_last_b;

   regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_dst   (a_dst),
      .a_data  (a_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_dst   (b_dst),
      .b_data  (b_data),
      .rf_w    (rf_w),
      .rf_we   (rf_we),
      .rf_in   (rf_in),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Regfile that the arbiter feeds.
   always @(posedge clk) begin
      if (!reset && rf_we) begin
         regs[rf_w] <= rf_in;
         wr_cnt     <= wr_cnt + 1;
      end
   end

   // Model: two queues plus a last-served flag; checked mid-cycle, then advanced for the next edge.
   always @(negedge clk) begin
      logic        e_ar, e_br, e_we, g_b;
      logic [34:0] head;
      logic [7:0]  e_pend;
      if (reset) begin
         qa.delete();
         qb.delete();
         m_last_b = 1'b1;
         chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
         chk("rst_rf_w", {29'd0, rf_w}, 32'd0);
         chk("rst_rf_in", rf_in, 32'd0);
         chk("rst_pending", {24'd0, pending}, 32'd0);
         chk("rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
      end else begin
         e_ar = (qa.size() < DEPTH);
         e_br = (qb.size() < DEPTH);
         e_we = (qa.size() > 0) || (qb.size() > 0);
         g_b  = (qa.size() == 0) || ((qb.size() > 0) && !m_last_b);
         head = '0;
         if (e_we) head = g_b ? qb[0] : qa[0];
         e_pend = '0;
         foreach (qa[k]) e_pend[qa[k][34:32]] = 1'b1;
         foreach (qb[k]) e_pend[qb[k][34:32]] = 1'b1;
         chk("a_ready", {31'd0, a_ready}, {31'd0, e_ar});
         chk("b_ready", {31'd0, b_ready}, {31'd0, e_br});
         chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
         chk("rf_w", {29'd0, rf_w}, {29'd0, head[34:32]});
         chk("rf_in", rf_in, head[31:0]);
         chk("pending", {24'd0, pending}, {24'd0, e_pend});
         if (e_we) begin
            if (g_b) void'(qb.pop_front());
            else     void'(qa.pop_front());
            m_last_b = g_b;
         end
         if (a_valid && e_ar) begin
            qa.push_back({a_dst, a_data});
            n_acc++;
         end
         if (b_valid && e_br) begin
            qb.push_back({b_dst, b_data});
            n_acc++;
         end
      end
   end

   task automatic drv(input logic av, input logic [2:0] ad, input logic [31:0] adat,
                      input logic bv, input logic [2:0] bd, input logic [31:0] bdat);
      a_valid = av; a_dst = ad; a_data = adat;
      b_valid = bv; b_dst = bd; b_data = bdat;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) regs[i] = '0;
      drv(0, 0, 0, 0, 0, 0);
      step();
      step();
      reset = 1'b0;

      // Single writer
      drv(1, 3'd0, 32'hABCDABCD, 0, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0);
      chk("single_we", {31'd0, rf_we}, 32'd1);
      chk("single_w", {29'd0, rf_w}, 32'd0);
      chk("single_in", rf_in, 32'hABCDABCD);
      chk("single_pend", {24'd0, pending}, 32'h01);
      step();
      chk("single_r0", regs[0], 32'hABCDABCD);
      chk("single_pend_clr", {24'd0, pending}, 32'h00);

      // Tie right after reset: A first
      do_reset();
      drv(1, 3'd0, 32'hABCDABCD, 1, 3'd1, 32'hDEADBEEF);
      step();
      drv(0, 0, 0, 0, 0, 0);
      chk("tie_w_a", {29'd0, rf_w}, 32'd0);
      chk("tie_in_a", rf_in, 32'hABCDABCD);
      chk("tie_pend", {24'd0, pending}, 32'h03);
      step();
      chk("tie_w_b", {29'd0, rf_w}, 32'd1);
      chk("tie_in_b", rf_in, 32'hDEADBEEF);
      step();
      chk("tie_r0", regs[0], 32'hABCDABCD);
      chk("tie_r1", regs[1], 32'hDEADBEEF);
      chk("tie_idle", {31'd0, rf_we}, 32'd0);

      // Same-register collision, last grant was B
      drv(1, 3'd3, 32'h11111111, 1, 3'd3, 32'h22222222);
      step();
      drv(0, 0, 0, 0, 0, 0);
      chk("coll_pend1", {31'd0, pending[3]}, 32'd1);
      step();
      chk("coll_pend2", {31'd0, pending[3]}, 32'd1);
      chk("coll_r3_mid", regs[3], 32'h11111111);
      step();
      chk("coll_pend3", {31'd0, pending[3]}, 32'd0);
      chk("coll_r3", regs[3], 32'h22222222);

      // Backpressure: both push every cycle
      for (int i = 0; i < 16; i++) begin
         drv(1, 3'(i % 8), 32'hA0000000 + i, 1, 3'((i + 3) % 8), 32'hB0000000 + i);
         step();
         if (i == 1) begin
            chk("bp_a_ready", {31'd0, a_ready}, 32'd1);
            chk("bp_b_ready", {31'd0, b_ready}, 32'd0);
         end
      end
      drv(0, 0, 0, 0, 0, 0);
      repeat (8) step();
      chk("bp_write_count", wr_cnt, n_acc);

      // Reset mid-operation
      for (int i = 0; i < 4; i++) begin
         drv(1, 3'd6, 32'hC0000000 + i, 1, 3'd7, 32'hD0000000 + i);
         step();
      end
      drv(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
      chk("mid_rst_pend", {24'd0, pending}, 32'd0);
      chk("mid_rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
      @(negedge clk);
      #1;
      reset = 1'b0;
      step();
      saved_wr = wr_cnt;
      repeat (4) step();
      chk("mid_rst_nowrite", wr_cnt, saved_wr);
      drv(1, 3'd5, 32'h55AA55AA, 0, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0);
      step();
      chk("post_rst_r5", regs[5], 32'h55AA55AA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
